// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, NOP encoding, fetch FSM states and
// the IF/ID pipeline register layout. Used by fetch, decode and later stages.
package pipeline_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {FS_RUN, FS_HALTED} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, addresses instruction memory, and captures {pc, instr} for
// decode. Honours stall, branch/jump redirect, and freezes after HALT.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   stall               - hold PC and IF/ID
//   redirect_valid/_pc  - EX-stage redirect to a new byte address
//   id_halt             - decode saw HALT (qualified with if_id_valid here)
//   imem_addr/_rdata    - combinational instruction memory interface
//   if_id_pc/_instr/_valid - IF/ID register contents
//   halted              - fetch frozen until reset
//   fetch_count         - valid instructions loaded into IF/ID
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_W     = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  input  logic            id_halt,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_e state_q;
  if_id_t       if_id_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic         halted_q;
  logic [31:0]  fetch_count_q;

  // Redirect targets are word aligned; the low two bits are discarded.
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (redirect_valid) pc_next = redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_RUN;
      pc_q          <= RESET_PC;
      if_id_q       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        FS_RUN: begin
          if (redirect_valid) begin
            // A halt seen alongside a redirect is on the wrong path.
            pc_q    <= pc_next;
            if_id_q <= '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
          end else if (id_halt && if_id_q.valid) begin
            state_q       <= FS_HALTED;
            halted_q      <= 1'b1;
            if_id_q.instr <= NOP_INSTR;
            if_id_q.valid <= 1'b0;
          end else if (!stall) begin
            pc_q          <= pc_next;
            if_id_q       <= '{pc: pc_q, instr: imem_rdata, valid: 1'b1};
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        FS_HALTED: begin
          halted_q <= 1'b1;
        end
        default: state_q <= FS_RUN;
      endcase
    end
  end

  assign imem_addr   = pc_q[PC_W+1:2];
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
